// File: rtl/scatter_sequencer_v2.sv
`default_nettype none
// ============================================================================
// Module      : scatter_sequencer_v2
// Description : Decodes 128-bit host packets into per-PU preload strobes and
//               sequences per-channel convolution control with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module scatter_sequencer_v2 #(
    parameter int NUM_PUS        = 64,
    parameter int ADDR_WIDTH     = 8,
    parameter int IMG_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int WEIGHT_WIDTH   = 16,
    parameter int BIAS_WIDTH     = 32,
    parameter int MAX_IMG_SIZE   = 32,
    parameter int MAX_CHANNELS   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [127:0]                     in_data,
    output logic                             in_ready,
    output logic                             image_preload_en,
    output logic [IMG_ADDR_WIDTH-1:0]        image_preload_addr,
    output logic [DATA_WIDTH-1:0]            image_preload_pixel,
    output logic [NUM_PUS-1:0]               bias_preload_en,
    output logic [NUM_PUS*ADDR_WIDTH-1:0]    bias_addr,
    output logic [NUM_PUS*BIAS_WIDTH-1:0]    bias_data,
    output logic [NUM_PUS-1:0]               weight_preload_en,
    output logic [NUM_PUS*ADDR_WIDTH-1:0]    weight_addr_pe0,
    output logic [NUM_PUS*ADDR_WIDTH-1:0]    weight_addr_pe1,
    output logic [NUM_PUS*ADDR_WIDTH-1:0]    weight_addr_pe2,
    output logic [NUM_PUS*WEIGHT_WIDTH-1:0]  weight_data_pe0,
    output logic [NUM_PUS*WEIGHT_WIDTH-1:0]  weight_data_pe1,
    output logic [NUM_PUS*WEIGHT_WIDTH-1:0]  weight_data_pe2,
    output logic [NUM_PUS*8-1:0]             filter_id,
    output logic [NUM_PUS*8-1:0]             channel_id,
    output logic                             clear,
    output logic                             image_preload_done,
    output logic [NUM_PUS-1:0]               load_weight_row,
    output logic [NUM_PUS-1:0]               bias_preload_done,
    output logic                             start_conv,
    output logic                             next_pixel,
    output logic                             channel_ready,
    output logic                             conv_done,
    output logic                             busy,
    output logic [7:0]                       cur_channel,
    output logic [15:0]                      err_cnt
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD_IMG  = 3'd1;
    localparam logic [2:0] c_ST_IMG_DONE  = 3'd2;
    localparam logic [2:0] c_ST_LOAD_ROW  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_CONV = 3'd4;
    localparam logic [2:0] c_ST_CONV      = 3'd5;
    localparam logic [2:0] c_ST_CH_DONE   = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    localparam logic [31:0] c_NUM_PUS  = 32'(NUM_PUS);
    localparam logic [7:0]  c_MAX_IMG  = 8'(MAX_IMG_SIZE);
    localparam logic [7:0]  c_MAX_CH   = 8'(MAX_CHANNELS);

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_cnt, r_pix_cnt, r_err;
    logic [7:0]  r_img_size, r_num_ch, r_cur_ch;
    logic        r_clear, r_start;
    logic        r_img_en;
    logic [IMG_ADDR_WIDTH-1:0] r_img_addr;
    logic [DATA_WIDTH-1:0]     r_img_pix;

    logic [NUM_PUS-1:0]      r_bias_en, r_wt_en, w_pu_sel;
    logic [ADDR_WIDTH-1:0]   r_bias_addr [NUM_PUS];
    logic [BIAS_WIDTH-1:0]   r_bias_data [NUM_PUS];
    logic [ADDR_WIDTH-1:0]   r_wa0 [NUM_PUS], r_wa1 [NUM_PUS], r_wa2 [NUM_PUS];
    logic [WEIGHT_WIDTH-1:0] r_wd0 [NUM_PUS], r_wd1 [NUM_PUS], r_wd2 [NUM_PUS];
    logic [7:0]              r_fid_lat [NUM_PUS], r_ch_lat [NUM_PUS];
    logic [7:0]              r_fid [NUM_PUS], r_chid [NUM_PUS];

    // Packet field decode
    logic [1:0]  w_type;
    logic [5:0]  w_pu;
    logic [7:0]  w_fid, w_chid, w_f0, w_f1;
    logic [31:0] w_pu_ext;
    logic        w_accept, w_pu_ok, w_good, w_drop;
    logic        w_do_img, w_do_bias, w_do_wt, w_do_cfg;
    logic [15:0] w_img16, w_pix_last, w_conv_last;
    logic        w_unused;

    assign w_type   = in_data[127:126];
    assign w_pu     = in_data[125:120];
    assign w_fid    = in_data[119:112];
    assign w_chid   = in_data[111:104];
    assign w_f0     = in_data[103:96];
    assign w_f1     = in_data[95:88];
    assign w_pu_ext = {26'd0, w_pu};
    assign w_unused = &{1'b0, in_data[31:0]};

    assign in_ready = (r_state != c_ST_WAIT_CONV) && (r_state != c_ST_CONV);
    assign w_accept = in_valid && in_ready;
    assign w_pu_ok  = (w_pu_ext < c_NUM_PUS);

    always_comb begin
        w_good = 1'b0;
        case (w_type)
            2'b00:   w_good = w_pu_ok && (r_state == c_ST_LOAD_IMG) && (w_chid == r_cur_ch);
            2'b11:   w_good = w_pu_ok && (r_state == c_ST_IDLE) && (w_f0 >= 8'd3) &&
                              (w_f0 <= c_MAX_IMG) && (w_f1 != 8'd0) && (w_f1 <= c_MAX_CH);
            default: w_good = w_pu_ok;
        endcase
    end

    assign w_drop    = w_accept && !w_good;
    assign w_do_img  = w_accept && w_good && (w_type == 2'b00);
    assign w_do_bias = w_accept && w_good && (w_type == 2'b01);
    assign w_do_wt   = w_accept && w_good && (w_type == 2'b10);
    assign w_do_cfg  = w_accept && w_good && (w_type == 2'b11);

    // Frame and sweep lengths, all truncated to 16 bits
    assign w_img16     = {8'd0, r_img_size};
    assign w_pix_last  = w_img16 * w_img16 - 16'd1;
    assign w_conv_last = w_img16 * (w_img16 - 16'd2) * 16'd3 - 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_do_cfg) w_state_nxt = c_ST_LOAD_IMG;
            c_ST_LOAD_IMG:  if (w_do_img && (r_pix_cnt == w_pix_last)) w_state_nxt = c_ST_IMG_DONE;
            c_ST_IMG_DONE:  w_state_nxt = c_ST_LOAD_ROW;
            c_ST_LOAD_ROW:  w_state_nxt = c_ST_WAIT_CONV;
            c_ST_WAIT_CONV: if (r_cnt == 16'd2) w_state_nxt = c_ST_CONV;
            c_ST_CONV:      if (r_cnt == w_conv_last) w_state_nxt = c_ST_CH_DONE;
            c_ST_CH_DONE:   w_state_nxt = (r_cur_ch == r_num_ch - 8'd1) ? c_ST_DONE : c_ST_LOAD_IMG;
            c_ST_DONE:      w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 16'd0;
            r_pix_cnt  <= 16'd0;
            r_err      <= 16'd0;
            r_img_size <= 8'd0;
            r_num_ch   <= 8'd0;
            r_cur_ch   <= 8'd0;
            r_clear    <= 1'b0;
            r_start    <= 1'b0;
            r_img_en   <= 1'b0;
            r_img_addr <= '0;
            r_img_pix  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_clear  <= w_do_cfg || ((r_state == c_ST_CH_DONE) && (w_state_nxt == c_ST_LOAD_IMG));
            r_start  <= (r_state == c_ST_WAIT_CONV) && (w_state_nxt == c_ST_CONV);
            r_img_en <= w_do_img;
            if (r_state != w_state_nxt)
                r_cnt <= 16'd0;
            else if ((r_state == c_ST_WAIT_CONV) || (r_state == c_ST_CONV))
                r_cnt <= r_cnt + 16'd1;
            if (w_do_img) begin
                r_img_addr <= IMG_ADDR_WIDTH'(w_f0);
                r_img_pix  <= DATA_WIDTH'(w_f1);
                r_pix_cnt  <= (r_pix_cnt == w_pix_last) ? 16'd0 : r_pix_cnt + 16'd1;
            end
            if (w_do_cfg) begin
                r_img_size <= w_f0;
                r_num_ch   <= w_f1;
                r_cur_ch   <= 8'd0;
                r_pix_cnt  <= 16'd0;
            end
            if ((r_state == c_ST_CH_DONE) && (w_state_nxt == c_ST_LOAD_IMG))
                r_cur_ch <= r_cur_ch + 8'd1;
            if (r_state == c_ST_DONE)
                r_cur_ch <= 8'd0;
            if (w_drop && (r_err != 16'hFFFF))
                r_err <= r_err + 16'd1;
        end
    end

    // Per-PU preload registers; only the addressed PU's slot moves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bias_en <= '0;
            r_wt_en   <= '0;
            for (int p = 0; p < NUM_PUS; p++) begin
                r_bias_addr[p] <= '0;
                r_bias_data[p] <= '0;
                r_wa0[p] <= '0; r_wa1[p] <= '0; r_wa2[p] <= '0;
                r_wd0[p] <= '0; r_wd1[p] <= '0; r_wd2[p] <= '0;
                r_fid_lat[p] <= 8'd0; r_ch_lat[p] <= 8'd0;
                r_fid[p] <= 8'd0; r_chid[p] <= 8'd0;
            end
        end else begin
            r_bias_en <= w_do_bias ? w_pu_sel : '0;
            r_wt_en   <= w_do_wt ? w_pu_sel : '0;
            for (int p = 0; p < NUM_PUS; p++) begin
                if (w_do_bias && w_pu_sel[p]) begin
                    r_bias_addr[p] <= ADDR_WIDTH'(w_f0);
                    r_bias_data[p] <= BIAS_WIDTH'(in_data[95:64]);
                end
                if (w_do_wt && w_pu_sel[p]) begin
                    r_wa0[p] <= ADDR_WIDTH'(in_data[103:96]);
                    r_wd0[p] <= WEIGHT_WIDTH'(in_data[95:80]);
                    r_wa1[p] <= ADDR_WIDTH'(in_data[79:72]);
                    r_wd1[p] <= WEIGHT_WIDTH'(in_data[71:56]);
                    r_wa2[p] <= ADDR_WIDTH'(in_data[55:48]);
                    r_wd2[p] <= WEIGHT_WIDTH'(in_data[47:32]);
                    r_fid_lat[p] <= w_fid;
                    r_ch_lat[p]  <= w_chid;
                end
                if (r_state == c_ST_LOAD_ROW) begin
                    r_fid[p]  <= r_fid_lat[p];
                    r_chid[p] <= r_ch_lat[p];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PUS; g++) begin : g_pu
            assign w_pu_sel[g] = (w_pu_ext == 32'(g));
            assign bias_addr[g*ADDR_WIDTH +: ADDR_WIDTH]         = r_bias_addr[g];
            assign bias_data[g*BIAS_WIDTH +: BIAS_WIDTH]         = r_bias_data[g];
            assign weight_addr_pe0[g*ADDR_WIDTH +: ADDR_WIDTH]   = r_wa0[g];
            assign weight_addr_pe1[g*ADDR_WIDTH +: ADDR_WIDTH]   = r_wa1[g];
            assign weight_addr_pe2[g*ADDR_WIDTH +: ADDR_WIDTH]   = r_wa2[g];
            assign weight_data_pe0[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_wd0[g];
            assign weight_data_pe1[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_wd1[g];
            assign weight_data_pe2[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = r_wd2[g];
            assign filter_id[g*8 +: 8]  = r_fid[g];
            assign channel_id[g*8 +: 8] = r_chid[g];
        end
    endgenerate

    assign image_preload_en    = r_img_en;
    assign image_preload_addr  = r_img_addr;
    assign image_preload_pixel = r_img_pix;
    assign bias_preload_en     = r_bias_en;
    assign weight_preload_en   = r_wt_en;
    assign clear               = r_clear;
    assign start_conv          = r_start;
    assign image_preload_done  = (r_state == c_ST_IMG_DONE) || (r_state == c_ST_LOAD_ROW) ||
                                 (r_state == c_ST_WAIT_CONV) || (r_state == c_ST_CONV);
    assign bias_preload_done   = {NUM_PUS{r_state == c_ST_IMG_DONE}};
    assign load_weight_row     = {NUM_PUS{r_state == c_ST_LOAD_ROW}};
    assign next_pixel          = (r_state == c_ST_CONV);
    assign channel_ready       = (r_state == c_ST_LOAD_IMG) && !(w_accept && (w_type == 2'b00));
    assign conv_done           = (r_state == c_ST_DONE);
    assign busy                = (r_state != c_ST_IDLE);
    assign cur_channel         = r_cur_ch;
    assign err_cnt             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scatter_sequencer_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_scatter_sequencer_v2
// Description : Directed self-checking bench for scatter_sequencer_v2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scatter_sequencer_v2;

    localparam int NP = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic in_ready, image_preload_en, clear, image_preload_done, start_conv;
    logic next_pixel, channel_ready, conv_done, busy;
    logic [11:0] image_preload_addr;
    logic [7:0]  image_preload_pixel, cur_channel;
    logic [15:0] err_cnt;
    logic [NP-1:0] bias_preload_en, weight_preload_en, load_weight_row, bias_preload_done;
    logic [NP*8-1:0]  bias_addr, weight_addr_pe0, weight_addr_pe1, weight_addr_pe2;
    logic [NP*32-1:0] bias_data;
    logic [NP*16-1:0] weight_data_pe0, weight_data_pe1, weight_data_pe2;
    logic [NP*8-1:0]  filter_id, channel_id;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    scatter_sequencer_v2 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .image_preload_en(image_preload_en), .image_preload_addr(image_preload_addr),
        .image_preload_pixel(image_preload_pixel), .bias_preload_en(bias_preload_en),
        .bias_addr(bias_addr), .bias_data(bias_data), .weight_preload_en(weight_preload_en),
        .weight_addr_pe0(weight_addr_pe0), .weight_addr_pe1(weight_addr_pe1),
        .weight_addr_pe2(weight_addr_pe2), .weight_data_pe0(weight_data_pe0),
        .weight_data_pe1(weight_data_pe1), .weight_data_pe2(weight_data_pe2),
        .filter_id(filter_id), .channel_id(channel_id), .clear(clear),
        .image_preload_done(image_preload_done), .load_weight_row(load_weight_row),
        .bias_preload_done(bias_preload_done), .start_conv(start_conv), .next_pixel(next_pixel),
        .channel_ready(channel_ready), .conv_done(conv_done), .busy(busy),
        .cur_channel(cur_channel), .err_cnt(err_cnt)
    );

    function automatic logic [127:0] mk_img(input logic [7:0] ch, input logic [7:0] addr,
                                            input logic [7:0] pix);
        return {2'b00, 6'd0, 8'd0, ch, addr, pix, 88'd0};
    endfunction

    function automatic logic [127:0] mk_bias(input logic [5:0] pu, input logic [7:0] addr,
                                             input logic [31:0] d);
        return {2'b01, pu, 8'd0, 8'd0, addr, d, 64'd0};
    endfunction

    function automatic logic [127:0] mk_cfg(input logic [7:0] sz, input logic [7:0] nch);
        return {2'b11, 6'd0, 8'd0, 8'd0, sz, nch, 88'd0};
    endfunction

    // Present one packet and hold it until the handshake completes
    task automatic send(input logic [127:0] p);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = p;
        while (in_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        vec++;
        if (n >= 300) begin
            errs++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        vec++; if (err_cnt !== 16'd0) begin errs++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        vec++; if ({next_pixel, conv_done, clear, start_conv, image_preload_en} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 00000",
                {next_pixel, conv_done, clear, start_conv, image_preload_en});
        end
    endtask

    task automatic test_bias();
        send(mk_bias(6'd5, 8'd3, 32'hDEADBEEF));
        vec++; if (bias_preload_en !== (64'd1 << 5)) begin
            errs++; $display("FAIL bias_en: got %h want %h", bias_preload_en, 64'd1 << 5); end
        vec++; if (bias_data[5*32 +: 32] !== 32'hDEADBEEF) begin
            errs++; $display("FAIL bias_data: got %h want deadbeef", bias_data[5*32 +: 32]); end
        vec++; if (bias_addr[5*8 +: 8] !== 8'd3) begin
            errs++; $display("FAIL bias_addr: got %0d want 3", bias_addr[5*8 +: 8]); end
        vec++; if (weight_preload_en !== '0) begin
            errs++; $display("FAIL bias_no_wt: got %h want 0", weight_preload_en); end
        @(posedge clk); #1;
        vec++; if (bias_preload_en !== '0) begin
            errs++; $display("FAIL bias_pulse: got %h want 0", bias_preload_en); end
    endtask

    task automatic test_weight();
        send({2'b10, 6'd63, 8'd7, 8'd2, 8'd1, 16'h1111, 8'd2, 16'h2222, 8'd3, 16'h3333, 32'd0});
        vec++; if (weight_preload_en !== (64'd1 << 63)) begin
            errs++; $display("FAIL wt_en: got %h want %h", weight_preload_en, 64'd1 << 63); end
        vec++; if (weight_addr_pe2[63*8 +: 8] !== 8'd3) begin
            errs++; $display("FAIL wt_addr2: got %0d want 3", weight_addr_pe2[63*8 +: 8]); end
        vec++; if (weight_data_pe1[63*16 +: 16] !== 16'h2222) begin
            errs++; $display("FAIL wt_data1: got %h want 2222", weight_data_pe1[63*16 +: 16]); end
        vec++; if (weight_data_pe0[63*16 +: 16] !== 16'h1111) begin
            errs++; $display("FAIL wt_data0: got %h want 1111", weight_data_pe0[63*16 +: 16]); end
        vec++; if (filter_id[63*8 +: 8] !== 8'd0) begin
            errs++; $display("FAIL wt_fid_early: got %0d want 0", filter_id[63*8 +: 8]); end
    endtask

    task automatic test_drops();
        send(mk_cfg(8'd2, 8'd1));
        send(mk_cfg(8'd33, 8'd1));
        vec++; if (err_cnt !== 16'd2) begin errs++; $display("FAIL drop_cfg_err: got %0d want 2", err_cnt); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL drop_cfg_busy: got %b want 0", busy); end
    endtask

    task automatic test_conv_backpressure();
        int np, st, bp, bad, cd, ch_seen;
        logic acc_next;
        send(mk_cfg(8'd4, 8'd2));
        vec++; if ({clear, busy, channel_ready, cur_channel} !== {3'b111, 8'd0}) begin
            errs++; $display("FAIL cfg_start: got clr/busy/rdy/ch=%b%b%b/%0d want 111/0",
                clear, busy, channel_ready, cur_channel); end
        send(mk_img(8'd1, 8'd0, 8'd0));
        vec++; if (err_cnt !== 16'd3 || image_preload_en !== 1'b0) begin
            errs++; $display("FAIL drop_img: got err=%0d en=%b want 3/0", err_cnt, image_preload_en); end
        for (int i = 0; i < 16; i++) begin
            send(mk_img(8'd0, 8'(i), 8'(i + 16)));
            if (i == 0) begin
                vec++; if ({image_preload_en, image_preload_addr, image_preload_pixel} !== {1'b1, 12'd0, 8'h10}) begin
                    errs++; $display("FAIL img_first: got en=%b a=%0d p=%h want 1/0/10",
                        image_preload_en, image_preload_addr, image_preload_pixel); end
            end
        end
        vec++; if ({image_preload_done, image_preload_addr, image_preload_pixel} !== {1'b1, 12'd15, 8'h1F}) begin
            errs++; $display("FAIL img_done: got d=%b a=%0d p=%h want 1/15/1f",
                image_preload_done, image_preload_addr, image_preload_pixel); end
        vec++; if (bias_preload_done !== {NP{1'b1}}) begin
            errs++; $display("FAIL bias_done: got %h want all ones", bias_preload_done); end
        @(posedge clk); #1;
        vec++; if (load_weight_row !== {NP{1'b1}}) begin
            errs++; $display("FAIL load_row: got %h want all ones", load_weight_row); end
        @(posedge clk); #1;
        vec++; if ({filter_id[63*8 +: 8], channel_id[63*8 +: 8], in_ready} !== {8'd7, 8'd2, 1'b0}) begin
            errs++; $display("FAIL ids: got fid=%0d ch=%0d rdy=%b want 7/2/0",
                filter_id[63*8 +: 8], channel_id[63*8 +: 8], in_ready); end
        // Hold a bias packet through the whole convolution of channel 0
        in_valid = 1'b1;
        in_data  = mk_bias(6'd1, 8'd9, 32'hA5A5A5A5);
        np = 0; st = 0; bp = 0; bad = 0; cd = 0; ch_seen = -1; acc_next = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (acc_next) begin in_valid = 1'b0; acc_next = 1'b0; end
            if (next_pixel) begin np++; if (ch_seen < 0) ch_seen = int'(cur_channel); end
            if (start_conv) st++;
            if (bias_preload_en[1]) bp++;
            if (conv_done) cd++;
            if (next_pixel && in_ready) bad++;
            if (in_valid && in_ready) acc_next = 1'b1;
            if (clear) break;
        end
        vec++; if (np !== 24) begin errs++; $display("FAIL np_ch0: got %0d want 24", np); end
        vec++; if (st !== 1) begin errs++; $display("FAIL start_ch0: got %0d want 1", st); end
        vec++; if (bp !== 1 || bad !== 0) begin
            errs++; $display("FAIL backpressure: got takes=%0d ready_in_conv=%0d want 1/0", bp, bad); end
        vec++; if (bias_data[1*32 +: 32] !== 32'hA5A5A5A5) begin
            errs++; $display("FAIL bp_data: got %h want a5a5a5a5", bias_data[1*32 +: 32]); end
        vec++; if (ch_seen !== 0 || cd !== 0 || cur_channel !== 8'd1) begin
            errs++; $display("FAIL ch0_seq: got ch=%0d done=%0d next=%0d want 0/0/1", ch_seen, cd, cur_channel); end
        for (int i = 0; i < 16; i++) send(mk_img(8'd1, 8'(i), 8'(i)));
        np = 0; cd = 0; ch_seen = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (next_pixel) begin np++; if (ch_seen < 0) ch_seen = int'(cur_channel); end
            if (conv_done) cd++;
            if (!busy) break;
        end
        vec++; if (np !== 24 || ch_seen !== 1) begin
            errs++; $display("FAIL ch1: got np=%0d ch=%0d want 24/1", np, ch_seen); end
        vec++; if (cd !== 1 || busy !== 1'b0 || cur_channel !== 8'd0) begin
            errs++; $display("FAIL layer_done: got done=%0d busy=%b ch=%0d want 1/0/0", cd, busy, cur_channel); end
        vec++; if (err_cnt !== 16'd3) begin errs++; $display("FAIL err_final: got %0d want 3", err_cnt); end
    endtask

    task automatic test_reset_mid_conv();
        int n, cd;
        send(mk_cfg(8'd3, 8'd1));
        for (int i = 0; i < 9; i++) send(mk_img(8'd0, 8'(i), 8'(i)));
        n = 0;
        while (next_pixel !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        vec++; if (next_pixel !== 1'b1) begin
            errs++; $display("FAIL mid_conv_reach: got next_pixel=%b want 1", next_pixel); end
        do_reset();
        vec++; if ({busy, in_ready, next_pixel, image_preload_done, conv_done} !== 5'b01000) begin
            errs++; $display("FAIL mid_reset: got b/r/np/ipd/cd=%b want 01000",
                {busy, in_ready, next_pixel, image_preload_done, conv_done}); end
        vec++; if (err_cnt !== 16'd0 || filter_id !== '0 || bias_data !== '0) begin
            errs++; $display("FAIL mid_reset_regs: got err=%0d fid63=%0d want 0/0", err_cnt, filter_id[63*8 +: 8]); end
        cd = 0;
        for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (conv_done) cd++; end
        vec++; if (cd !== 0) begin errs++; $display("FAIL mid_reset_done: got %0d pulses want 0", cd); end
    endtask

    initial begin
        test_reset();
        test_bias();
        test_weight();
        test_drops();
        test_conv_backpressure();
        test_reset_mid_conv();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
